// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types and helpers for the register-bus arbiter.
//   arb_state_e            : arbiter FSM states
//   DEFAULT_TIMEOUT_CYCLES : default BUSY-cycle limit before a forced error
//   idx_width()            : width needed to index n requesters (at least 1 bit)
package reg_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

  // A single requester still needs a 1-bit index so vectors stay legal.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Register-map bus between the arbiter (master) and the register map (slave).
//   req/is_wr/addr/wr_data/wr_strobe : request side, driven by the master
//   ready/err/rd_data                : completion side, driven by the slave
interface reg_bus_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    req;
  logic                    is_wr;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strobe;
  logic                    ready;
  logic                    err;
  logic [DATA_WIDTH-1:0]   rd_data;

  modport master (
    output req, is_wr, addr, wr_data, wr_strobe,
    input  ready, err, rd_data
  );

  modport slave (
    input  req, is_wr, addr, wr_data, wr_strobe,
    output ready, err, rd_data
  );
endinterface

// File: rtl/reg_bus_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req         : request vector
//   ptr         : highest-priority index
//   grant_valid : any request present
//   grant_idx   : first set bit at or above ptr, wrapping to 0
module rr_pick #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_WIDTH   = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_WIDTH-1:0]   ptr,
  output logic                   grant_valid,
  output logic [IDX_WIDTH-1:0]   grant_idx
);

  // Rotate so the pointer position lands at bit 0, then a plain
  // lowest-set-bit search gives the offset from the pointer.
  logic [2*NUM_MASTERS-1:0] req_dbl;
  logic [NUM_MASTERS-1:0]   req_rot;
  logic [IDX_WIDTH-1:0]     offset;
  logic [IDX_WIDTH:0]       sum;

  assign req_dbl = {req, req};
  assign req_rot = NUM_MASTERS'(req_dbl >> ptr);

  always_comb begin
    offset = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = IDX_WIDTH'(k);
    end
  end

  assign sum         = {1'b0, ptr} + {1'b0, offset};
  assign grant_valid = |req;
  assign grant_idx   = (sum >= (IDX_WIDTH + 1)'(NUM_MASTERS))
                       ? IDX_WIDTH'(sum - (IDX_WIDTH + 1)'(NUM_MASTERS))
                       : IDX_WIDTH'(sum);

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register-map bus between NUM_MASTERS
// requesters, one outstanding transfer, with a response timeout.
//   clk, reset       : clock, asynchronous active-low reset
//   m_req/m_req_is_wr/m_addr/m_wr_data/m_wr_strobe : packed requester inputs
//   m_ready/m_err    : one-cycle completion pulse and error qualifier
//   m_rd_data        : read data shared by all requesters
//   bus              : register-map bus (master side)
module reg_bus_arbiter
  import reg_bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_req_is_wr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wr_data,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wr_strobe,
  output logic [NUM_MASTERS-1:0]            m_ready,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [DATA_WIDTH-1:0]             m_rd_data,
  reg_bus_if.master                         bus
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = idx_width(NUM_MASTERS);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   bus_req_q, bus_req_d;
  logic                   bus_is_wr_q, bus_is_wr_d;
  logic [ADDR_WIDTH-1:0]  bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0]  bus_wr_data_q, bus_wr_data_d;
  logic [SW-1:0]          bus_wr_strobe_q, bus_wr_strobe_d;
  logic [NUM_MASTERS-1:0] m_ready_q, m_ready_d;
  logic [NUM_MASTERS-1:0] m_err_q, m_err_d;
  logic [DATA_WIDTH-1:0]  m_rd_data_q, m_rd_data_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          done;
  logic          expire;

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_WIDTH   (IW)
  ) u_pick (
    .req         (m_req),
    .ptr         (ptr_q),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  assign done   = bus.ready | bus.err;
  assign expire = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      grant_q         <= '0;
      cnt_q           <= '0;
      bus_req_q       <= 1'b0;
      bus_is_wr_q     <= 1'b0;
      bus_addr_q      <= '0;
      bus_wr_data_q   <= '0;
      bus_wr_strobe_q <= '0;
      m_ready_q       <= '0;
      m_err_q         <= '0;
      m_rd_data_q     <= '0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      grant_q         <= grant_d;
      cnt_q           <= cnt_d;
      bus_req_q       <= bus_req_d;
      bus_is_wr_q     <= bus_is_wr_d;
      bus_addr_q      <= bus_addr_d;
      bus_wr_data_q   <= bus_wr_data_d;
      bus_wr_strobe_q <= bus_wr_strobe_d;
      m_ready_q       <= m_ready_d;
      m_err_q         <= m_err_d;
      m_rd_data_q     <= m_rd_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = BUSY;
      BUSY:    if (done || expire) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    ptr_d           = ptr_q;
    grant_d         = grant_q;
    cnt_d           = cnt_q;
    bus_req_d       = bus_req_q;
    bus_is_wr_d     = bus_is_wr_q;
    bus_addr_d      = bus_addr_q;
    bus_wr_data_d   = bus_wr_data_q;
    bus_wr_strobe_d = bus_wr_strobe_q;
    m_ready_d       = '0;
    m_err_d         = '0;
    m_rd_data_d     = m_rd_data_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d         = pick_idx;
          bus_req_d       = 1'b1;
          bus_is_wr_d     = m_req_is_wr[pick_idx];
          bus_addr_d      = m_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          bus_wr_data_d   = m_wr_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          bus_wr_strobe_d = m_wr_strobe[pick_idx*SW +: SW];
          cnt_d           = '0;
        end
      end
      BUSY: begin
        // A real completion takes precedence over an expiring timeout.
        if (done) begin
          bus_req_d          = 1'b0;
          m_ready_d[grant_q] = 1'b1;
          m_err_d[grant_q]   = bus.err;
          m_rd_data_d        = bus.rd_data;
        end else if (expire) begin
          bus_req_d          = 1'b0;
          m_ready_d[grant_q] = 1'b1;
          m_err_d[grant_q]   = 1'b1;
          m_rd_data_d        = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.req       = bus_req_q;
  assign bus.is_wr     = bus_is_wr_q;
  assign bus.addr      = bus_addr_q;
  assign bus.wr_data   = bus_wr_data_q;
  assign bus.wr_strobe = bus_wr_strobe_q;
  assign m_ready       = m_ready_q;
  assign m_err         = m_err_q;
  assign m_rd_data     = m_rd_data_q;

endmodule
